// File: rtl/vram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_loader                                                                |
// | Byte-stream command bridge: parses W/C/R packets into VRAM/control bus     |
// | strobes and streams VRAM read-back bytes out on a valid/ready port.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vram_loader #(
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 1200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              sel_ram,
    output logic              sel_ctl,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        din,
    input  logic [7:0]        ram_dout,
    input  logic [7:0]        ctl_dout,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_AH  = 3'd1,
        HDR_AL  = 3'd2,
        HDR_CNT = 3'd3,
        WDATA   = 3'd4,
        RADDR   = 3'd5,
        RWAIT   = 3'd6,
        RSEND   = 3'd7
    } state_t;

    // Address is assembled as {ADDR_HI[HI_W-1:0], ADDR_LO}; ADDR_W must lie in 9..16.
    localparam int                HI_W     = ADDR_W - 8;
    localparam int                TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [7:0]        CMD_W    = 8'h57;
    localparam logic [7:0]        CMD_C    = 8'h43;
    localparam logic [7:0]        CMD_R    = 8'h52;

    state_t            state, state_n;
    logic              is_read, is_read_n;
    logic              is_ctl, is_ctl_n;
    logic [HI_W-1:0]   addr_hi, addr_hi_n;
    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [8:0]        cnt, cnt_n;
    logic [TMR_W-1:0]  timer, timer_n;

    logic              sel_ram_n, sel_ctl_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        din_n;
    logic [7:0]        tx_data_n;
    logic              tx_valid_n;
    logic              err_n;

    logic              rx_fire;
    logic              timed;
    logic              unused_ctl;

    assign unused_ctl = ^ctl_dout;

    assign rx_ready = !reset && (state inside {IDLE, HDR_AH, HDR_AL, HDR_CNT, WDATA});
    assign rx_fire  = rx_valid && rx_ready;
    assign timed    = state inside {HDR_AH, HDR_AL, HDR_CNT, WDATA};

    // The registered strobe keeps busy high through the final write cycle.
    assign busy     = (state != IDLE) || sel_ram || sel_ctl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            is_read  <= 1'b0;
            is_ctl   <= 1'b0;
            addr_hi  <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            timer    <= '0;
            sel_ram  <= 1'b0;
            sel_ctl  <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            din      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            is_read  <= is_read_n;
            is_ctl   <= is_ctl_n;
            addr_hi  <= addr_hi_n;
            cur_addr <= cur_addr_n;
            cnt      <= cnt_n;
            timer    <= timer_n;
            sel_ram  <= sel_ram_n;
            sel_ctl  <= sel_ctl_n;
            we       <= we_n;
            addr     <= addr_n;
            din      <= din_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        is_read_n  = is_read;
        is_ctl_n   = is_ctl;
        addr_hi_n  = addr_hi;
        cur_addr_n = cur_addr;
        cnt_n      = cnt;
        timer_n    = (rx_fire || !timed) ? '0 : timer + TMR_ONE;
        sel_ram_n  = 1'b0;
        sel_ctl_n  = 1'b0;
        we_n       = 1'b0;
        addr_n     = addr;
        din_n      = din;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        CMD_W: begin
                            is_read_n = 1'b0;
                            is_ctl_n  = 1'b0;
                            state_n   = HDR_AH;
                        end
                        CMD_C: begin
                            is_read_n = 1'b0;
                            is_ctl_n  = 1'b1;
                            state_n   = HDR_AH;
                        end
                        CMD_R: begin
                            is_read_n = 1'b1;
                            is_ctl_n  = 1'b0;
                            state_n   = HDR_AH;
                        end
                        default: err_n = 1'b1;
                    endcase
                end
            end
            HDR_AH: begin
                if (rx_fire) begin
                    addr_hi_n = rx_data[HI_W-1:0];
                    state_n   = HDR_AL;
                end
            end
            HDR_AL: begin
                if (rx_fire) begin
                    cur_addr_n = {addr_hi, rx_data};
                    state_n    = HDR_CNT;
                end
            end
            HDR_CNT: begin
                if (rx_fire) begin
                    cnt_n = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    if (is_read) begin
                        state_n   = RADDR;
                        sel_ram_n = 1'b1;
                        addr_n    = cur_addr;
                    end else begin
                        state_n = WDATA;
                    end
                end
            end
            WDATA: begin
                if (rx_fire) begin
                    sel_ram_n  = !is_ctl;
                    sel_ctl_n  = is_ctl;
                    we_n       = 1'b1;
                    addr_n     = cur_addr;
                    din_n      = rx_data;
                    cur_addr_n = cur_addr + ADDR_ONE;
                    cnt_n      = cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        state_n = IDLE;
                    end
                end
            end
            RADDR: begin
                state_n = RWAIT;
            end
            RWAIT: begin
                tx_data_n  = ram_dout;
                tx_valid_n = 1'b1;
                state_n    = RSEND;
            end
            RSEND: begin
                if (tx_valid && tx_ready) begin
                    tx_valid_n = 1'b0;
                    cur_addr_n = cur_addr + ADDR_ONE;
                    cnt_n      = cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        state_n = IDLE;
                    end else begin
                        // Strobe for the next read is registered on entry to RADDR.
                        state_n   = RADDR;
                        sel_ram_n = 1'b1;
                        addr_n    = cur_addr + ADDR_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (timed && !rx_fire && (timer == TMR_LAST)) begin
            state_n   = IDLE;
            sel_ram_n = 1'b0;
            sel_ctl_n = 1'b0;
            we_n      = 1'b0;
            err_n     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vram_loader                                                             |
// | Directed bench for vram_loader with a model RAM returning addr[7:0].       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vram_loader;

    localparam int ADDR_W  = 13;
    localparam int TIMEOUT = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sel_ram;
    logic              sel_ctl;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        ram_dout;
    logic [7:0]        ctl_dout;
    logic              busy;
    logic              err;

    logic [7:0]        ram_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sel_ram && !we) ram_q <= addr[7:0];
    end
    assign ram_dout = ram_q;
    assign ctl_dout = 8'h00;

    vram_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sel_ram  (sel_ram),
        .sel_ctl  (sel_ctl),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .ram_dout (ram_dout),
        .ctl_dout (ctl_dout),
        .busy     (busy),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus snapshot packed as {sel_ram, sel_ctl, we, addr}.
    function automatic logic [31:0] bus_now();
        return {16'd0, sel_ram, sel_ctl, we, addr};
    endfunction

    function automatic logic [31:0] bus_exp(input logic r, input logic c, input logic w,
                                            input logic [ADDR_W-1:0] a);
        return {16'd0, r, c, w, a};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        tick();
    endtask

    initial begin
        int n;
        int good;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();
        check("rx_ready_in_reset", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_bus", bus_now(), bus_exp(1'b0, 1'b0, 1'b0, 13'h0000));
        check("rst_din", 32'(din), 32'h00);
        check("rst_tx", {23'd0, tx_valid, tx_data}, 32'h000);
        check("rst_busy_err", {30'd0, busy, err}, 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);

        // VRAM write, back-to-back bytes
        send_byte(8'h57);
        check("w_busy_rise", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h03);
        check("w_no_strobe_hdr", bus_now(), bus_exp(1'b0, 1'b0, 1'b0, addr));
        send_byte(8'hAA);
        check("w0_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h0010));
        check("w0_din", 32'(din), 32'hAA);
        send_byte(8'hBB);
        check("w1_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h0011));
        check("w1_din", 32'(din), 32'hBB);
        send_byte(8'hCC);
        rx_valid = 1'b0;
        check("w2_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h0012));
        check("w2_din", 32'(din), 32'hCC);
        check("w2_busy", 32'(busy), 32'd1);
        tick();
        check("w_after_strobe", {31'd0, sel_ram}, 32'd0);
        check("w_busy_fall", 32'(busy), 32'd0);

        // VRAM read, tx_ready low for one cycle per byte before the handshake
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h02);
        rx_valid = 1'b0;
        check("r0_strobe", bus_now(), bus_exp(1'b1, 1'b0, 1'b0, 13'h0010));
        check("r0_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        check("r0_wait", {30'd0, sel_ram, tx_valid}, 32'd0);
        tick();
        check("r0_tx", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h10});
        tick();
        check("r0_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h10});
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("r1_strobe", bus_now(), bus_exp(1'b1, 1'b0, 1'b0, 13'h0011));
        check("r1_tx_cleared", 32'(tx_valid), 32'd0);
        tick();
        check("r1_wait", 32'(tx_valid), 32'd0);
        tick();
        check("r1_tx", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h11});
        tick();
        check("r1_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h11});
        check("r1_busy", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("r_end", {29'd0, tx_valid, busy, sel_ram}, 32'd0);
        check("r_end_rx_ready", 32'(rx_ready), 32'd1);

        // Control write
        send_byte(8'h43);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h5A);
        rx_valid = 1'b0;
        check("c_bus", bus_now(), bus_exp(1'b0, 1'b1, 1'b1, 13'h0003));
        check("c_din", 32'(din), 32'h5A);
        tick();
        check("c_after", {30'd0, sel_ram, sel_ctl}, 32'd0);

        // Address wrap, excess high address bits ignored
        send_byte(8'h57);
        send_byte(8'h1F);
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'h11);
        check("wrap0_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h1FFF));
        check("wrap0_din", 32'(din), 32'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        check("wrap1_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h0000));
        check("wrap1_din", 32'(din), 32'h22);
        tick();
        check("wrap_err", 32'(err), 32'd0);
        send_byte(8'h57);
        send_byte(8'hE0);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h33);
        rx_valid = 1'b0;
        check("hi_mask_bus", bus_now(), bus_exp(1'b1, 1'b0, 1'b1, 13'h0005));
        tick();

        // COUNT of zero means 256 data bytes
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        good = 0;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (sel_ram && we && !sel_ctl && addr == 13'(i) && din == 8'(i)) good++;
        end
        rx_valid = 1'b0;
        check("c256_strobes", 32'(good), 32'd256);
        tick();
        check("c256_done", {30'd0, busy, sel_ram}, 32'd0);

        // Unknown command
        send_byte(8'h99);
        rx_valid = 1'b0;
        check("bad_cmd_err", 32'(err), 32'd1);
        check("bad_cmd_quiet", {29'd0, busy, sel_ram, sel_ctl}, 32'd0);
        tick();
        check("bad_cmd_err_pulse", 32'(err), 32'd0);

        // Timeout inside a header, then a normal packet
        send_byte(8'h57);
        send_byte(8'h00);
        rx_valid = 1'b0;
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_idle", 32'(busy), 32'd0);
        tick();
        check("timeout_err_pulse", 32'(err), 32'd0);
        send_byte(8'h43);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h77);
        rx_valid = 1'b0;
        check("post_to_bus", bus_now(), bus_exp(1'b0, 1'b1, 1'b1, 13'h0005));
        check("post_to_din", 32'(din), 32'h77);
        tick();

        // Reset while a read byte is waiting for tx_ready
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h01);
        rx_valid = 1'b0;
        tick();
        tick();
        check("rr_tx", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h20});
        reset = 1'b1;
        tick();
        check("rr_cleared", {28'd0, tx_valid, busy, sel_ram, sel_ctl}, 32'd0);
        check("rr_rx_ready_in_reset", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("rr_rx_ready", 32'(rx_ready), 32'd1);
        check("rr_quiet", {29'd0, tx_valid, busy, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
